regfile_wr_arbiter: RTL

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regarb_pkg.sv | 14 +
 rtl/regarb_scoreboard.sv | 43 ++++
 rtl/regfile_wr_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regarb_pkg.sv
// rtl/regarb_pkg.sv - shared widths and FSM state type for the register-file write arbiter
package regarb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int PEND_W     = 1 << REG_ADDR_W;
    localparam int CNT_W      = 4;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_FORCE_B = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regarb_scoreboard.sv
// rtl/regarb_scoreboard.sv - per-register pending-write mask for requester B destinations
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   set_en, set_addr    reserve a destination (address 0 never becomes pending)
//   clr_en, clr_addr    release a destination when its B write completes
//   pend                one bit per architectural register
module regarb_scoreboard
    import regarb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [PEND_W-1:0]     pend
);

    logic [PEND_W-1:0] set_mask;
    logic [PEND_W-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_addr != '0)) begin
            set_mask = PEND_W'(1) << set_addr;
        end
        if (clr_en) begin
            clr_mask = PEND_W'(1) << clr_addr;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit pending.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester arbiter for the single register-file write port
//
// Ports:
//   clk_i, rst_n_i                        clock, asynchronous active-low reset
//   a_valid_i/a_ready_o/a_addr_i/a_data_i pipeline writeback requester (priority)
//   b_valid_i/b_ready_o/b_addr_i/b_data_i multi-cycle unit requester (anti-starvation)
//   RegWrite_o/RDaddr_o/RDdata_o          registered register-file write port
//   claim_i/claim_addr_i                  issue-time reservation of a B destination
//   pend_o                                per-register pending-write mask
// Build option: REGARB_SCOREBOARD_EN enables the pending mask; otherwise pend_o is 0.
module regfile_wr_arbiter
    import regarb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [REG_ADDR_W-1:0] a_addr_i,
    input  logic [REG_DATA_W-1:0] a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [REG_ADDR_W-1:0] b_addr_i,
    input  logic [REG_DATA_W-1:0] b_data_i,
    output logic                  RegWrite_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic [REG_DATA_W-1:0] RDdata_o,
    input  logic                  claim_i,
    input  logic [REG_ADDR_W-1:0] claim_addr_i,
    output logic [PEND_W-1:0]     pend_o
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             a_xfer;
    logic             b_xfer;

    always_comb begin
        a_ready_o    = 1'b0;
        b_ready_o    = 1'b0;
        state_nxt    = ST_NORMAL;
        wait_cnt_nxt = wait_cnt;

        case (state)
            ST_NORMAL: begin
                a_ready_o = a_valid_i;
                b_ready_o = b_valid_i & ~a_valid_i;
            end
            ST_FORCE_B: begin
                b_ready_o = 1'b1;
            end
            default: begin
                a_ready_o = 1'b0;
                b_ready_o = 1'b0;
            end
        endcase

        // Handshakes must not be offered while reset is held.
        if (!rst_n_i) begin
            a_ready_o = 1'b0;
            b_ready_o = 1'b0;
        end

        a_xfer = a_valid_i & a_ready_o;
        b_xfer = b_valid_i & b_ready_o;

        if (!b_valid_i || b_xfer) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
        end

        // Force B on the edge where its wait count reaches the limit.
        if ((state == ST_NORMAL) && b_valid_i && !b_ready_o && (wait_cnt_nxt >= LIMIT)) begin
            state_nxt = ST_FORCE_B;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_NORMAL;
            wait_cnt   <= '0;
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            // Writes to r0 are accepted and tracked on the bus but never strobed.
            if (a_xfer) begin
                RegWrite_o <= (a_addr_i != '0);
                RDaddr_o   <= a_addr_i;
                RDdata_o   <= a_data_i;
            end else if (b_xfer) begin
                RegWrite_o <= (b_addr_i != '0);
                RDaddr_o   <= b_addr_i;
                RDdata_o   <= b_data_i;
            end else begin
                RegWrite_o <= 1'b0;
            end
        end
    end

`ifdef REGARB_SCOREBOARD_EN
    regarb_scoreboard u_scoreboard (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .set_en   (claim_i),
        .set_addr (claim_addr_i),
        .clr_en   (b_xfer),
        .clr_addr (b_addr_i),
        .pend     (pend_o)
    );
`else
    logic unused_claim;
    assign unused_claim = ^{claim_i, claim_addr_i};
    assign pend_o       = '0;
`endif

endmodule
